// File: rtl/halflife_pkg.sv
// ============================================================================
// Module   : halflife_pkg
// Brief    : Shared types and defaults for the half-life decay sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package halflife_pkg;

    localparam int HL_WIDTH        = 4;
    localparam int HL_PER_W        = 16;
    localparam int HL_HALVINGS_MAX = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_HALVE = 3'd3,
        S_DONE  = 3'd4
    } hl_state_t;

endpackage : halflife_pkg

`default_nettype wire

// File: rtl/halflife_seq_if.sv
// ============================================================================
// Module   : halflife_seq_if
// Brief    : Control/readback bundle between pin wrapper, sequencer and counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface halflife_seq_if #(
    parameter int WIDTH = 4,
    parameter int PER_W = 16
) ();

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] init_val;
    logic [PER_W-1:0] period;
    logic             up_req;
    logic             down_req;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_up;
    logic             cnt_down;
    logic             busy;
    logic             done;
    logic [3:0]       halvings;

    // Wrapper/counter side: drives requests and readback, observes controls.
    modport master (
        output start, abort, init_val, period, up_req, down_req, cnt_val,
        input  cnt_load, cnt_load_val, cnt_up, cnt_down, busy, done, halvings
    );

    modport slave (
        input  start, abort, init_val, period, up_req, down_req, cnt_val,
        output cnt_load, cnt_load_val, cnt_up, cnt_down, busy, done, halvings
    );

endinterface : halflife_seq_if

`default_nettype wire

// File: rtl/halflife_prescaler.sv
// ============================================================================
// Module   : halflife_prescaler
// Brief    : Half-life period tick counter; a period of 0 behaves as 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module halflife_prescaler #(
    parameter int PER_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear_i,
    input  wire logic             en_i,
    input  wire logic [PER_W-1:0] period_i,
    output logic                  tick_o
);

    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_d;
    logic [PER_W-1:0] w_term;

    assign w_term = (period_i == '0) ? '0 : period_i - 1'b1;
    assign tick_o = (cnt_q == w_term);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : halflife_prescaler

`default_nettype wire

// File: rtl/halflife_seq.sv
// ============================================================================
// Module   : halflife_seq
// Brief    : Half-life decay sequencer owning the counter load/up/down controls.
//            Define HALFLIFE_MANUAL_EN to enable manual up/down arbitration in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module halflife_seq
    import halflife_pkg::*;
#(
    parameter int WIDTH = HL_WIDTH,
    parameter int PER_W = HL_PER_W
) (
    input  wire logic     clk,
    input  wire logic     reset,
    halflife_seq_if.slave bus
);

    hl_state_t        state_q, state_d;
    logic [WIDTH-1:0] amt_q, amt_d;
    logic [3:0]       halv_q, halv_d;

    logic             w_tick;
    logic             w_presc_clear;
    logic             w_presc_en;
    logic [WIDTH-1:0] w_half;
    logic             w_abort;

    assign w_half        = bus.cnt_val >> 1;
    assign w_abort       = bus.abort && (state_q != S_IDLE);
    assign w_presc_clear = (state_q == S_IDLE) && bus.start;
    assign w_presc_en    = (state_q == S_WAIT) && !bus.abort;

    halflife_prescaler #(
        .PER_W (PER_W)
    ) u_presc (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_presc_clear),
        .en_i     (w_presc_en),
        .period_i (bus.period),
        .tick_o   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            amt_q   <= '0;
            halv_q  <= '0;
        end else begin
            state_q <= state_d;
            amt_q   <= amt_d;
            halv_q  <= halv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        amt_d   = amt_q;
        halv_d  = halv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    amt_d   = bus.init_val;
                    halv_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = (amt_q == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (w_tick) state_d = S_HALVE;
            S_HALVE: begin
                if (halv_q != 4'(HL_HALVINGS_MAX)) begin
                    halv_d = halv_q + 4'd1;
                end
                state_d = (w_half == '0) ? S_DONE : S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including the halvings update above.
        if (w_abort) begin
            state_d = S_IDLE;
            halv_d  = halv_q;
        end
    end

    // Abort also suppresses the load/done of the cycle in which it is sampled.
    always_comb begin
        bus.cnt_load     = 1'b0;
        bus.cnt_load_val = '0;
        bus.done         = 1'b0;
        bus.busy         = (state_q != S_IDLE);
        bus.halvings     = halv_q;
        case (state_q)
            S_LOAD: begin
                bus.cnt_load     = !w_abort;
                bus.cnt_load_val = w_abort ? '0 : amt_q;
            end
            S_HALVE: begin
                bus.cnt_load     = !w_abort;
                bus.cnt_load_val = w_abort ? '0 : w_half;
            end
            S_DONE:  bus.done = !w_abort;
            default: ;
        endcase
    end

`ifdef HALFLIFE_MANUAL_EN
    assign bus.cnt_up   = (state_q == S_IDLE) && bus.up_req && !bus.down_req;
    assign bus.cnt_down = (state_q == S_IDLE) && bus.down_req && !bus.up_req;
`else
    logic w_unused_req;
    assign w_unused_req = ^{bus.up_req, bus.down_req};
    assign bus.cnt_up   = 1'b0;
    assign bus.cnt_down = 1'b0;
`endif

endmodule : halflife_seq

`default_nettype wire

// File: tb/tb_halflife_seq.sv
// ============================================================================
// Module   : tb_halflife_seq
// Brief    : Directed self-checking bench for halflife_seq with a counter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_halflife_seq;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;
    logic [3:0] r_cnt;

    halflife_seq_if #(.WIDTH(4), .PER_W(16)) bus ();

    halflife_seq #(.WIDTH(4), .PER_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 4-bit up/down counter with synchronous load.
    always @(posedge clk or posedge reset) begin
        if (reset)             r_cnt <= 4'd0;
        else if (bus.cnt_load) r_cnt <= bus.cnt_load_val;
        else if (bus.cnt_up)   r_cnt <= r_cnt + 4'd1;
        else if (bus.cnt_down) r_cnt <= r_cnt - 4'd1;
    end
    assign bus.cnt_val = r_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".load"}, {31'd0, bus.cnt_load}, 32'd0);
        chk({tag, ".lval"}, {28'd0, bus.cnt_load_val}, 32'd0);
        chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, ".up"},   {31'd0, bus.cnt_up}, 32'd0);
        chk({tag, ".down"}, {31'd0, bus.cnt_down}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_vals [4];
        n_asserts = 0;
        n_fail    = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.init_val = '0; bus.period = '0;
        bus.up_req = 1'b0; bus.down_req = 1'b0;
        #12;
        chk_idle_outs("reset");
        chk("reset.halv", {28'd0, bus.halvings}, 32'd0);
        reset = 1'b0;
        cyc();

        // Normal run: 12 -> 6 -> 3 -> 1 -> 0, period 3.
        exp_vals[0] = 4'd6; exp_vals[1] = 4'd3; exp_vals[2] = 4'd1; exp_vals[3] = 4'd0;
        bus.init_val = 4'd12; bus.period = 16'd3; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("run.load0", {31'd0, bus.cnt_load}, 32'd1);
        chk("run.lval0", {28'd0, bus.cnt_load_val}, 32'd12);
        chk("run.busy",  {31'd0, bus.busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                cyc();
                chk("run.wait_load", {31'd0, bus.cnt_load}, 32'd0);
            end
            cyc();
            chk("run.halve_load", {31'd0, bus.cnt_load}, 32'd1);
            chk("run.halve_lval", {28'd0, bus.cnt_load_val}, {28'd0, exp_vals[k]});
        end
        cyc();
        chk("run.done", {31'd0, bus.done}, 32'd1);
        chk("run.halv", {28'd0, bus.halvings}, 32'd4);
        chk("run.cnt0", {28'd0, r_cnt}, 32'd0);
        cyc();
        chk("run.done_off", {31'd0, bus.done}, 32'd0);
        chk("run.busy_off", {31'd0, bus.busy}, 32'd0);
        chk("run.halv_hold", {28'd0, bus.halvings}, 32'd4);

        // Zero amount: load 0 then done immediately.
        bus.init_val = 4'd0; bus.period = 16'd5; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("zamt.load", {31'd0, bus.cnt_load}, 32'd1);
        chk("zamt.lval", {28'd0, bus.cnt_load_val}, 32'd0);
        cyc();
        chk("zamt.done", {31'd0, bus.done}, 32'd1);
        chk("zamt.halv", {28'd0, bus.halvings}, 32'd0);
        cyc();
        chk("zamt.busy", {31'd0, bus.busy}, 32'd0);

        // Zero period behaves as period 1.
        bus.init_val = 4'd1; bus.period = 16'd0; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("zper.lval", {28'd0, bus.cnt_load_val}, 32'd1);
        cyc();
        chk("zper.wait", {31'd0, bus.cnt_load}, 32'd0);
        cyc();
        chk("zper.load2", {31'd0, bus.cnt_load}, 32'd1);
        chk("zper.lval2", {28'd0, bus.cnt_load_val}, 32'd0);
        cyc();
        chk("zper.done", {31'd0, bus.done}, 32'd1);
        chk("zper.halv", {28'd0, bus.halvings}, 32'd1);
        cyc();

        // Abort in the 4th WAIT cycle; a mid-run start is ignored.
        bus.init_val = 4'd15; bus.period = 16'd10; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("abt.lval", {28'd0, bus.cnt_load_val}, 32'd15);
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        chk("abt.restart_ignored", {31'd0, bus.cnt_load}, 32'd0);
        chk("abt.busy_w3", {31'd0, bus.busy}, 32'd1);
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk_idle_outs("abt");
        chk("abt.cnt", {28'd0, r_cnt}, 32'd15);
        chk("abt.halv", {28'd0, bus.halvings}, 32'd0);
        cyc();
        chk("abt.nodone", {31'd0, bus.done}, 32'd0);

        // Manual arbitration.
        bus.up_req = 1'b1;
        #1;
`ifdef HALFLIFE_MANUAL_EN
        chk("man.up", {31'd0, bus.cnt_up}, 32'd1);
        bus.down_req = 1'b1;
        #1;
        chk("man.both_up", {31'd0, bus.cnt_up}, 32'd0);
        chk("man.both_dn", {31'd0, bus.cnt_down}, 32'd0);
        bus.up_req = 1'b0;
        #1;
        chk("man.down", {31'd0, bus.cnt_down}, 32'd1);
        bus.up_req = 1'b1; bus.down_req = 1'b0;
`else
        chk("man.up_off", {31'd0, bus.cnt_up}, 32'd0);
        bus.down_req = 1'b1; bus.up_req = 1'b0;
        #1;
        chk("man.dn_off", {31'd0, bus.cnt_down}, 32'd0);
        bus.up_req = 1'b1; bus.down_req = 1'b0;
`endif
        bus.init_val = 4'd8; bus.period = 16'd2; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("man.busy_up", {31'd0, bus.cnt_up}, 32'd0);
        bus.up_req = 1'b0;

        // Async reset during HALVE.
        cyc();
        cyc();
        cyc();
        chk("rst.halve_lval", {28'd0, bus.cnt_load_val}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outs("rst");
        chk("rst.halv", {28'd0, bus.halvings}, 32'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst.nodone", {31'd0, bus.done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_halflife_seq

`default_nettype wire
